seq_mul_unit: RTL

Iterative shift-add unsigned multiplier functional unit for the Tomasulo execution stage.
- Accepts one operation (ROB/RS tag plus two operands) from its reservation station.
- Computes the full 2*DATA_W product over DATA_W cycles, one partial-product add per cycle, on a DATA_W-bit ripple-carry adder.
- Holds the result on its CDB request port until the CDB arbiter grants it.

---
 rtl/seq_mul_unit_pkg.sv | 23 ++
 rtl/seq_mul_unit_if.sv | 31 +++
 rtl/seq_mul_unit_rca.sv | 39 +++
 rtl/seq_mul_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/seq_mul_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier unit.
// Provides the FSM state encoding, the default operand and tag widths, and
// the derivation of the iteration-counter width from the operand width.
package mul_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 6;

    // Counter width for a given operand width. It only has to reach
    // data_w-1, because the last iteration leaves BUSY instead of counting on.
    function automatic int cnt_width(input int data_w);
        return ($clog2(data_w) < 1) ? 1 : $clog2(data_w);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DATA_W);

endpackage

// File: rtl/seq_mul_unit_if.sv
// Issue and CDB channels of the multiplier functional unit.
//   issue_*  : operation offered by the reservation station (valid/ready)
//   cdb_*    : completed result offered to the CDB arbiter (valid/grant)
// master = RS / arbiter side, slave = functional unit side.
interface seq_mul_unit_if
    import mul_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
);
    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic [DATA_W-1:0] issue_src_a;
    logic [DATA_W-1:0] issue_src_b;
    logic              cdb_valid;
    logic              cdb_grant;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_lo;
    logic [DATA_W-1:0] cdb_hi;

    modport master (
        output issue_valid, issue_tag, issue_src_a, issue_src_b, cdb_grant,
        input  issue_ready, cdb_valid, cdb_tag, cdb_lo, cdb_hi
    );

    modport slave (
        input  issue_valid, issue_tag, issue_src_a, issue_src_b, cdb_grant,
        output issue_ready, cdb_valid, cdb_tag, cdb_lo, cdb_hi
    );
endinterface

// File: rtl/seq_mul_unit_rca.sv
// Ripple-carry adder built from a chain of 1-bit full-adder cells.
//   full_adder         : a, b, ci -> s, co (single bit)
//   ripple_carry_adder : a[W], b[W], ci -> s[W], co
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ci,
    output logic [DATA_W-1:0] s,
    output logic              co
);
    logic [DATA_W:0] carry_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry_s[i]),
            .s  (s[i]),
            .co (carry_s[i+1])
        );
    end

    assign co = carry_s[DATA_W];
endmodule

// File: rtl/seq_mul_unit.sv
// Iterative shift-add unsigned multiplier for the Tomasulo execution stage.
// Accepts one tagged op, runs DATA_W add/shift iterations on a DATA_W-bit
// ripple adder, then holds the 2*DATA_W-bit product on the CDB request
// until granted.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   flush : squashes any in-flight or pending op (highest priority)
//   bus   : issue channel (valid/ready) and CDB channel (valid/grant)
module seq_mul_unit
    import mul_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    seq_mul_unit_if.slave bus
);
    localparam int CNT_W = cnt_width(DATA_W);

    state_t              state_r;
    logic [CNT_W-1:0]    count_r;
    logic [TAG_W-1:0]    tag_r;
    logic [DATA_W-1:0]   a_r;
    // Product register. The architectural register is one bit wider, but
    // its top bit is always zero after the logical right shift, so only the
    // low 2*DATA_W bits are stored.
    logic [2*DATA_W-1:0] p_r;
    logic                cdb_valid_r;

    logic [DATA_W-1:0]   addend_s;
    logic [DATA_W-1:0]   sum_s;
    logic                carry_s;
    logic [2*DATA_W-1:0] p_next_s;
    logic                last_iter_s;

    // Partial-product selection: add the multiplicand when the current LSB
    // of the multiplier half is set.
    always_comb begin
        if (p_r[0]) begin
            addend_s = a_r;
        end else begin
            addend_s = {DATA_W{1'b0}};
        end
    end

    ripple_carry_adder #(
        .DATA_W (DATA_W)
    ) u_rca (
        .a  (p_r[2*DATA_W-1:DATA_W]),
        .b  (addend_s),
        .ci (1'b0),
        .s  (sum_s),
        .co (carry_s)
    );

    // The carry-out enters as the new top bit, so it becomes product bit
    // 2*DATA_W-1 after the final shift.
    assign p_next_s    = {carry_s, sum_s, p_r[DATA_W-1:1]};
    assign last_iter_s = (count_r == CNT_W'(DATA_W - 1));

    // Control FSM and datapath registers; flush overrides issue and grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CNT_W{1'b0}};
            tag_r       <= {TAG_W{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            p_r         <= {(2*DATA_W){1'b0}};
            cdb_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= IDLE;
            cdb_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.issue_valid && bus.issue_ready) begin
                        tag_r   <= bus.issue_tag;
                        a_r     <= bus.issue_src_a;
                        p_r     <= {{DATA_W{1'b0}}, bus.issue_src_b};
                        count_r <= {CNT_W{1'b0}};
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    p_r <= p_next_s;
                    if (last_iter_s) begin
                        // Hold the counter here so it never wraps.
                        state_r     <= DONE;
                        cdb_valid_r <= 1'b1;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.cdb_grant) begin
                        state_r     <= IDLE;
                        cdb_valid_r <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cdb_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue_ready = (state_r == IDLE) & ~flush;
    assign bus.cdb_valid   = cdb_valid_r;
    assign bus.cdb_tag     = tag_r;
    assign bus.cdb_lo      = p_r[DATA_W-1:0];
    assign bus.cdb_hi      = p_r[2*DATA_W-1:DATA_W];

endmodule
